sort_pkt_checker: RTL



---
 rtl/sort_pkt_checker.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/sort_pkt_checker.sv
// Receive-side checker for the sort engine output stream: verifies framing,
// non-decreasing order and length per packet, and reports length/checksum.
module sort_pkt_checker #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 10,
  parameter int CWIDTH = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              sop_i,
  input  logic              eop_i,
  input  logic              val_i,
  input  logic              clr_i,
  output logic              pkt_done_o,
  output logic              pkt_ok_o,
  output logic [AWIDTH:0]   pkt_len_o,
  output logic [DWIDTH-1:0] pkt_sum_o,
  output logic              err_order_o,
  output logic              err_proto_o,
  output logic              err_len_o,
  output logic [CWIDTH-1:0] pkt_cnt_o,
  output logic [CWIDTH-1:0] err_cnt_o
);

  localparam logic [AWIDTH:0] LEN_ONE = {{AWIDTH{1'b0}}, 1'b1};
  localparam logic [AWIDTH:0] LEN_MAX = {1'b1, {AWIDTH{1'b0}}};
  localparam logic [AWIDTH:0] LEN_SAT = LEN_MAX | LEN_ONE;
  localparam logic [CWIDTH-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, IN_PKT} state_t;

  typedef struct packed {
    logic              vld;
    logic              ok;
    logic              order;
    logic              proto;
    logic              lenf;
    logic [AWIDTH:0]   len;
    logic [DWIDTH-1:0] sum;
  } rpt_t;

  state_t            state_q, state_d;
  logic [DWIDTH-1:0] prev_q, prev_d, sum_q, sum_d;
  logic [AWIDTH:0]   len_q, len_d;
  logic              ord_q, ord_d, lenf_q, lenf_d;
  rpt_t              rpt;
  logic              stray;

  // Packet state as it would stand after accepting the current word.
  logic              w_ord, w_lenf;
  logic [AWIDTH:0]   w_len;
  logic [DWIDTH-1:0] w_sum;

  always_comb begin
    w_ord  = ord_q | (data_i < prev_q);
    w_lenf = lenf_q | (len_q >= LEN_MAX);
    w_len  = (len_q >= LEN_MAX) ? LEN_SAT : len_q + LEN_ONE;
    w_sum  = sum_q + data_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      prev_q  <= '0;
      len_q   <= '0;
      sum_q   <= '0;
      ord_q   <= 1'b0;
      lenf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      len_q   <= len_d;
      sum_q   <= sum_d;
      ord_q   <= ord_d;
      lenf_q  <= lenf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    len_d   = len_q;
    sum_d   = sum_q;
    ord_d   = ord_q;
    lenf_d  = lenf_q;
    rpt     = '0;
    stray   = 1'b0;
    if (val_i) begin
      unique case (state_q)
        IDLE: begin
          if (sop_i) begin
            prev_d = data_i;
            len_d  = LEN_ONE;
            sum_d  = data_i;
            ord_d  = 1'b0;
            lenf_d = 1'b0;
            if (eop_i) begin
              rpt.vld = 1'b1;
              rpt.ok  = 1'b1;
              rpt.len = LEN_ONE;
              rpt.sum = data_i;
            end else begin
              state_d = IN_PKT;
            end
          end else begin
            stray = 1'b1;
          end
        end
        IN_PKT: begin
          if (sop_i) begin
            // Premature sop closes the open packet as failed; the sop word is dropped.
            rpt.vld   = 1'b1;
            rpt.proto = 1'b1;
            rpt.order = ord_q;
            rpt.lenf  = lenf_q;
            rpt.len   = len_q;
            rpt.sum   = sum_q;
            state_d   = IDLE;
          end else begin
            prev_d = data_i;
            len_d  = w_len;
            sum_d  = w_sum;
            ord_d  = w_ord;
            lenf_d = w_lenf;
            if (eop_i) begin
              rpt.vld   = 1'b1;
              rpt.ok    = ~(w_ord | w_lenf);
              rpt.order = w_ord;
              rpt.lenf  = w_lenf;
              rpt.len   = w_len;
              rpt.sum   = w_sum;
              state_d   = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  logic pkt_inc, err_inc;
  assign pkt_inc = rpt.vld;
  assign err_inc = (rpt.vld & ~rpt.ok) | stray;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pkt_done_o  <= 1'b0;
      pkt_ok_o    <= 1'b0;
      pkt_len_o   <= '0;
      pkt_sum_o   <= '0;
      err_order_o <= 1'b0;
      err_proto_o <= 1'b0;
      err_len_o   <= 1'b0;
      pkt_cnt_o   <= '0;
      err_cnt_o   <= '0;
    end else begin
      pkt_done_o <= rpt.vld;
      if (rpt.vld) begin
        pkt_ok_o  <= rpt.ok;
        pkt_len_o <= rpt.len;
        pkt_sum_o <= rpt.sum;
      end
      if (clr_i) begin
        err_order_o <= 1'b0;
        err_proto_o <= 1'b0;
        err_len_o   <= 1'b0;
        pkt_cnt_o   <= '0;
        err_cnt_o   <= '0;
      end else begin
        err_order_o <= err_order_o | (rpt.vld & rpt.order);
        err_proto_o <= err_proto_o | (rpt.vld & rpt.proto) | stray;
        err_len_o   <= err_len_o | (rpt.vld & rpt.lenf);
        if (pkt_inc && pkt_cnt_o != CNT_MAX) pkt_cnt_o <= pkt_cnt_o + CWIDTH'(1);
        if (err_inc && err_cnt_o != CNT_MAX) err_cnt_o <= err_cnt_o + CWIDTH'(1);
      end
    end
  end

endmodule
